// File: rtl/matrix_3x3_gen_pkg.sv
// Shared types and tap layout for the 3x3 window generator and the kernels
// that unpack its output.
package matrix_3x3_gen_pkg;

  localparam int DATA_W   = 24;
  localparam int TAP_NUM  = 9;
  localparam int MATRIX_W = DATA_W * TAP_NUM;

  typedef logic [DATA_W-1:0] pix_t;

  // LSB of tap (r,c); r=1 is the oldest row, c=1 the oldest column.
  function automatic int tap_lsb(input int r, input int c);
    return ((r - 1) * 3 + (c - 1)) * DATA_W;
  endfunction

endpackage

// File: rtl/matrix_3x3_gen_line_buffer.sv
// One line of pixel storage: simple dual-port RAM, read-first, 1-cycle read.
module matrix_3x3_gen_line_buffer
  import matrix_3x3_gen_pkg::*;
#(
  parameter int DEPTH = 1280,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] raddr,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // Write and registered read in one process: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus per-row column shift
// registers give nine taps per accepted pixel, 2 cycles after the input.
// Build option MATRIX_EDGE_REPLICATE_EN: out-of-frame taps replicate the
// nearest valid column/row instead of reading as zero.
module matrix_3x3_gen
  import matrix_3x3_gen_pkg::*;
#(
  parameter logic [11:0] IMG_HDISP = 12'd1280,
  parameter logic [11:0] IMG_VDISP = 12'd720
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_vs,
  input  logic                pre_de,
  input  logic [DATA_W-1:0]   pre_data,
  output logic                matrix_vs,
  output logic                matrix_de,
  output logic [MATRIX_W-1:0] matrix_data
);

  localparam int XW = $clog2(int'(IMG_HDISP) + 1);
  localparam int AW = (IMG_HDISP > 12'd1) ? $clog2(int'(IMG_HDISP)) : 1;

  // Vertical size only matters downstream; reject nonsense geometry at elaboration.
  if (IMG_VDISP == 12'd0 || IMG_HDISP < 12'd2) begin : g_cfg_chk
    $error("matrix_3x3_gen: unsupported image geometry");
  end

  logic          vs_d1, de_d1;
  logic [XW-1:0] x, x_cur, x_d1;
  logic [1:0]    rows_seen, rows_cur, rows_d1;
  logic          vs_rise, de_fall, acc, acc_d1;
  pix_t          data_d1, lb1_q, lb2_q;

  pix_t sr   [1:3][1:2];
  pix_t win  [1:3][1:3];
  pix_t tap  [1:3][1:3];
  logic [MATRIX_W-1:0] tap_bus;

  // A frame start clears the counters in the same cycle, so a pixel arriving
  // with the pre_vs rise is x=0 of row 0.
  assign vs_rise  = pre_vs & ~vs_d1;
  assign de_fall  = ~pre_de & de_d1;
  assign x_cur    = vs_rise ? '0 : x;
  assign rows_cur = vs_rise ? 2'd0 : rows_seen;
  assign acc      = pre_de & (x_cur < XW'(IMG_HDISP));

  // Edge detectors, column counter (saturates past the line end) and row count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d1     <= 1'b0;
      de_d1     <= 1'b0;
      x         <= '0;
      rows_seen <= 2'd0;
    end else begin
      vs_d1 <= pre_vs;
      de_d1 <= pre_de;
      if (de_fall)
        x <= '0;
      else if (pre_de && x_cur != XW'(IMG_HDISP))
        x <= x_cur + XW'(1);
      else
        x <= x_cur;
      if (de_fall && !vs_rise && rows_cur != 2'd2)
        rows_seen <= rows_cur + 2'd1;
      else
        rows_seen <= rows_cur;
    end
  end

  // Stage 1: align the current pixel and its coordinates with the RAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_d1  <= 1'b0;
      x_d1    <= '0;
      rows_d1 <= 2'd0;
      data_d1 <= '0;
    end else begin
      acc_d1  <= acc;
      x_d1    <= x_cur;
      rows_d1 <= rows_cur;
      data_d1 <= pre_data;
    end
  end

  // lb1 holds row y-1; its displaced word moves to lb2 (row y-2) one cycle later.
  matrix_3x3_gen_line_buffer #(.DEPTH(int'(IMG_HDISP)), .AW(AW)) u_lb1 (
    .clk   (clk),
    .we    (acc),
    .waddr (x_cur[AW-1:0]),
    .wdata (pre_data),
    .raddr (x_cur[AW-1:0]),
    .rdata (lb1_q)
  );

  matrix_3x3_gen_line_buffer #(.DEPTH(int'(IMG_HDISP)), .AW(AW)) u_lb2 (
    .clk   (clk),
    .we    (acc_d1),
    .waddr (x_d1[AW-1:0]),
    .wdata (lb1_q),
    .raddr (x_cur[AW-1:0]),
    .rdata (lb2_q)
  );

  // Window for this pixel: two stored older columns plus the newly arrived column.
  always_comb begin
    for (int r = 1; r <= 3; r++) begin
      win[r][1] = sr[r][1];
      win[r][2] = sr[r][2];
    end
    win[1][3] = lb2_q;
    win[2][3] = lb1_q;
    win[3][3] = data_d1;
  end

  // Column shift registers advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (acc_d1) begin
      for (int r = 1; r <= 3; r++) begin
        sr[r][1] <= win[r][2];
        sr[r][2] <= win[r][3];
      end
    end
  end

`ifdef MATRIX_EDGE_REPLICATE_EN
  pix_t colr [1:3][1:3];

  // Missing columns copy the oldest valid column (column 0 of the line).
  always_comb begin
    colr = win;
    for (int r = 1; r <= 3; r++) begin
      if (x_d1 == '0) begin
        colr[r][1] = win[r][3];
        colr[r][2] = win[r][3];
      end else if (x_d1 == XW'(1)) begin
        colr[r][1] = win[r][2];
      end
    end
  end

  // Missing rows then copy the oldest valid row as a whole.
  always_comb begin
    tap = colr;
    if (rows_d1 == 2'd0) begin
      tap[1] = colr[3];
      tap[2] = colr[3];
    end else if (rows_d1 == 2'd1) begin
      tap[1] = colr[2];
    end
  end
`else
  // Out-of-frame taps read as zero; this also hides stale RAM after reset/pre_vs.
  always_comb begin
    tap = win;
    for (int r = 1; r <= 3; r++) begin
      for (int c = 1; c <= 3; c++) begin
        if ((c == 1 && x_d1 < XW'(2)) || (c == 2 && x_d1 == '0) ||
            (r == 1 && rows_d1 < 2'd2) || (r == 2 && rows_d1 == 2'd0))
          tap[r][c] = '0;
      end
    end
  end
`endif

  // Pack the nine taps into the output bus layout.
  always_comb begin
    tap_bus = '0;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        tap_bus[tap_lsb(r, c) +: DATA_W] = tap[r][c];
  end

  // Stage 2: registered outputs; data holds between valid tap sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix_vs   <= 1'b0;
      matrix_de   <= 1'b0;
      matrix_data <= '0;
    end else begin
      matrix_vs <= vs_d1;
      matrix_de <= acc_d1;
      if (acc_d1) matrix_data <= tap_bus;
    end
  end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Self-checking bench for matrix_3x3_gen with IMG_HDISP=4: directed pattern
// frames followed by random frames, checked against a coordinate-level model.
module tb_matrix_3x3_gen;
  import matrix_3x3_gen_pkg::*;

  localparam logic [11:0] HD = 12'd4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                pre_vs = 1'b0;
  logic                pre_de = 1'b0;
  logic [DATA_W-1:0]   pre_data = '0;
  logic                matrix_vs, matrix_de;
  logic [MATRIX_W-1:0] matrix_data;

  matrix_3x3_gen #(.IMG_HDISP(HD), .IMG_VDISP(12'd8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_vs      (pre_vs),
    .pre_de      (pre_de),
    .pre_data    (pre_data),
    .matrix_vs   (matrix_vs),
    .matrix_de   (matrix_de),
    .matrix_data (matrix_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [MATRIX_W-1:0] act,
                     input logic [MATRIX_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Reference: pixels of the current frame by (row, column); window taps are
  // the pixels at (y-3+r, x-3+c).
  typedef struct {
    int                  cyc;
    logic [MATRIX_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  logic [DATA_W-1:0] frame_px [0:63][0:3];
  int y = 0;

  function automatic logic [MATRIX_W-1:0] exp_win(input int yy, input int xx);
    logic [MATRIX_W-1:0] w;
    logic [DATA_W-1:0]   v;
    int py, px;
    w = '0;
    for (int r = 1; r <= 3; r++) begin
      for (int c = 1; c <= 3; c++) begin
        py = yy - 3 + r;
        px = xx - 3 + c;
`ifdef MATRIX_EDGE_REPLICATE_EN
        if (py < 0) py = 0;
        if (px < 0) px = 0;
        v = frame_px[py][px];
`else
        if (py < 0 || px < 0) v = '0;
        else v = frame_px[py][px];
`endif
        w[((r - 1) * 3 + (c - 1)) * DATA_W +: DATA_W] = v;
      end
    end
    return w;
  endfunction

  // Drive one line of len pixels followed by gap idle cycles.
  task automatic drive_line(input int len, input int gap, input bit pat, input bit vs_first);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      pre_vs = vs_first && (i == 0);
      if (vs_first && i == 0) y = 0;
      d = pat ? (24'h010000 + 24'(y * 16 + i)) : 24'($urandom);
      pre_de   = 1'b1;
      pre_data = d;
      if (i < 4) begin
        frame_px[y][i] = d;
        sb.push_back('{cyc + 2, exp_win(y, i)});
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      pre_vs   = 1'b0;
      pre_de   = 1'b0;
      pre_data = 24'($urandom);
    end
    y++;
  endtask

  task automatic new_frame(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      pre_vs = 1'b1;
      pre_de = 1'b0;
    end
    y = 0;
  endtask

  // Monitor: matrix_vs is pre_vs two cycles back (zero across reset), matrix_de
  // and taps follow the scoreboard, everything zero while reset is sampled.
  bit r1 = 1'b0, r2 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  always @(negedge clk) begin
    logic exp_vs, exp_de;
    exp_vs = r1 & r2 & p2;
    exp_de = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("matrix_vs", MATRIX_W'(matrix_vs), MATRIX_W'(exp_vs));
    chk("matrix_de", MATRIX_W'(matrix_de), MATRIX_W'(exp_de));
    if (!r1) chk("reset_data", matrix_data, '0);
    if (exp_de) begin
      if (r1) chk("taps", matrix_data, sb[0].data);
      void'(sb.pop_front());
    end
    r2 = r1; r1 = rst_n;
    p2 = p1; p1 = pre_vs;
  end

  initial begin
    // Reset with toggling inputs.
    repeat (3) begin
      @(posedge clk); #1;
      pre_vs   = 1'($urandom);
      pre_de   = 1'($urandom);
      pre_data = 24'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; pre_vs = 1'b0; pre_de = 1'b0;
    repeat (2) @(posedge clk);

    // Frame after reset: rows 0..2, a 5-pixel line (last dropped), then one more.
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(5, 2, 1'b1, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0);

    // New frame after two lines: previous rows must be masked again.
    new_frame(2);
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(4, 3, 1'b1, 1'b0);
    new_frame(1);
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0);

    // Frame start coinciding with the first pixel.
    drive_line(4, 1, 1'b1, 1'b1);
    drive_line(4, 1, 1'b1, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0);

    // Random frames.
    repeat (8) begin
      int nl;
      bit vf;
      nl = 1 + int'($urandom % 5);
      vf = 1'($urandom);
      if (!vf) new_frame(1 + int'($urandom % 3));
      for (int l = 0; l < nl; l++)
        drive_line(($urandom % 5 == 0) ? 5 : 4, 1 + int'($urandom % 3), 1'b0, vf && (l == 0));
    end

    // Drain: every expected tap set must have appeared.
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain", MATRIX_W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
